// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry, pixel format and arbiter state encoding
// for the VGA scan-out path.
package vga_pkg;

  localparam int unsigned FB_W      = 160;
  localparam int unsigned FB_H      = 120;
  localparam int unsigned FB_DEPTH  = FB_W * FB_H;
  localparam int unsigned FB_ADDR_W = 15;
  localparam int unsigned PIX_W     = 6;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_CLEAR = 1'b1
  } arb_state_e;

  localparam logic [PIX_W-1:0] COL_BLACK = 6'b000000;
  localparam logic [PIX_W-1:0] COL_WHITE = 6'b111111;

  // Pack 2:2:2 colour components into one pixel word.
  function automatic logic [PIX_W-1:0] rgb222(input logic [1:0] r,
                                              input logic [1:0] g,
                                              input logic [1:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Frame-buffer arbiter bus: display fetch, pixel writer, clear control
// and the single-port RAM side, grouped for the arbiter and its environment.
interface vga_fb_arbiter_if
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W = FB_ADDR_W,
  parameter int unsigned DATA_W = PIX_W
);

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_rdata_valid;
  logic [DATA_W-1:0] disp_rdata;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;
  logic              clr_done;
  logic              wr_starved;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data,
           clr_start, clr_color, mem_rdata,
    output disp_rdata_valid, disp_rdata, wr_ready, clr_busy, clr_done,
           wr_starved, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data,
           clr_start, clr_color, mem_rdata,
    input  disp_rdata_valid, disp_rdata, wr_ready, clr_busy, clr_done,
           wr_starved, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/vga_fb_clear_seq.sv
// Screen-clear sequencer: owns the IDLE/CLEAR state, the fill address
// counter, the latched fill colour and the busy/done status.
module vga_fb_clear_seq
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W = FB_ADDR_W,
  parameter int unsigned DATA_W = PIX_W,
  parameter int unsigned DEPTH  = FB_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] color,
  input  logic              step,
  output arb_state_e        state,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] color_q,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  arb_state_e        state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] color_d;
  logic              busy_d;
  logic              done_d;

  // Next state: start only honoured from IDLE; counter holds at the last address.
  always_comb begin
    state_d = state;
    addr_d  = addr;
    color_d = color_q;
    done_d  = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (start) begin
          state_d = ARB_CLEAR;
          addr_d  = '0;
          color_d = color;
        end
      end
      ARB_CLEAR: begin
        if (step) begin
          if (addr == LAST_ADDR) begin
            state_d = ARB_IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d = addr + ADDR_W'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d == ARB_CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      addr    <= '0;
      color_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      addr    <= addr_d;
      color_q <= color_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer scheduler: display reads win every cycle they
// are requested; clear fill and writer traffic use the leftover slots.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W       = FB_ADDR_W,
  parameter int unsigned DATA_W       = PIX_W,
  parameter int unsigned DEPTH        = FB_DEPTH,
  parameter int unsigned STARVE_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_fb_arbiter_if.master bus
);

  localparam int unsigned         STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e        state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_color_q;
  logic              clr_busy_q;
  logic              clr_done_q;

  logic              clr_step_c;
  logic              wr_ready_c;
  logic              wr_fire_c;

  logic              mem_en_d,    mem_en_q;
  logic              mem_we_d,    mem_we_q;
  logic [ADDR_W-1:0] mem_addr_d,  mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic              rd_valid_q;

  logic [STARVE_W-1:0] starve_cnt_d, starve_cnt_q;
  logic                wr_starved_d, wr_starved_q;

  assign clr_step_c = (state == ARB_CLEAR) && !bus.disp_req;
  assign wr_ready_c = (state == ARB_IDLE) && !bus.disp_req;
  assign wr_fire_c  = bus.wr_valid && wr_ready_c;

  vga_fb_clear_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (bus.clr_start),
    .color   (bus.clr_color),
    .step    (clr_step_c),
    .state   (state),
    .addr    (clr_addr),
    .color_q (clr_color_q),
    .busy    (clr_busy_q),
    .done    (clr_done_q)
  );

  // Fixed-priority pick of this cycle's RAM access; address/data hold when idle.
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (bus.disp_req) begin
      mem_en_d   = 1'b1;
      mem_addr_d = bus.disp_addr;
    end else if (clr_step_c) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = clr_addr;
      mem_wdata_d = clr_color_q;
    end else if (wr_fire_c) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = bus.wr_addr;
      mem_wdata_d = bus.wr_data;
    end
  end

  // Any un-accepted writer cycle is a blocked cycle; an accepted write clears history.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    wr_starved_d = wr_starved_q;
    if (wr_fire_c) begin
      starve_cnt_d = '0;
      wr_starved_d = 1'b0;
    end else if (bus.wr_valid && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
    if (starve_cnt_d == STARVE_MAX) begin
      wr_starved_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_valid_q   <= 1'b0;
      starve_cnt_q <= '0;
      wr_starved_q <= 1'b0;
    end else begin
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_valid_q   <= mem_en_q && !mem_we_q;
      starve_cnt_q <= starve_cnt_d;
      wr_starved_q <= wr_starved_d;
    end
  end

  // RAM read data arrives in the valid cycle itself, so it is forwarded
  // directly and forced to zero whenever no display read is returning.
  assign bus.disp_rdata_valid = rd_valid_q;
  assign bus.disp_rdata       = rd_valid_q ? bus.mem_rdata : '0;
  assign bus.wr_ready         = wr_ready_c;
  assign bus.clr_busy         = clr_busy_q;
  assign bus.clr_done         = clr_done_q;
  assign bus.wr_starved       = wr_starved_q;
  assign bus.mem_en           = mem_en_q;
  assign bus.mem_we           = mem_we_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_wdata        = mem_wdata_q;

endmodule
